sha256_stream_padder: RTL
=========================

SHA256_STREAM_PADDER -- requirements
Module: sha256_stream_padder

Interface
REQ-001 The block SHALL have one parameter: LEN_W, default 64, the width of the message bit-length counter, zero-extended into the 64-bit length field.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_data  in  32  message word, big-endian; first byte in [31:24].
- s_valid  in  1  s_data valid.
- s_ready  out  1  padder accepts s_data this cycle.
- s_last  in  1  final word of message.
- s_bytes  in  2  valid bytes in final word: 0 means 4, 1..3 literal; ignored unless s_last.
- mode  in  1  1 = SHA-256, 0 = SHA-224; sampled on first word of message.
- core_init  out  1  one-cycle pulse issuing first block.
- core_next  out  1  one-cycle pulse issuing later blocks.
- core_mode  out  1  latched mode.
- core_block  out  512  block; word 0 in [511:480].
- core_ready  in  1  hash core idle.
- busy  out  1  message in progress (first word accepted, msg_done not yet pulsed).
- msg_done  out  1  one-cycle pulse: final digest valid at core.

Function
REQ-004 The FSM SHALL have the states FILL, ISSUE, WAIT and EXTRA; the reset state is FILL.
REQ-005 s_ready SHALL be 1 only in FILL; a word is accepted when s_valid and s_ready are both high.
REQ-006 Accepted words SHALL be stored at word index w (0..15), big-endian, and w SHALL increment.
- After a non-last word with w=15 the FSM SHALL go to ISSUE.
REQ-007 The bit counter SHALL add 32 per non-last word and 8*b on the last word (b = 4 if s_bytes=0).
- The counter wraps modulo 2^LEN_W.
REQ-008 On the last word, let n = 4*w + b be the message bytes in the block. Byte n SHALL be 0x80 and bytes above n SHALL be zero.
- n<=55: words 14-15 SHALL hold the 64-bit bit count; single final block.
- 56<=n<=63: the current block is emitted, then an EXTRA block of zeros with the count in words 14-15.
- n=64: the current block is emitted, then an EXTRA block with word 0 = 0x80000000, zeros, and the count.
REQ-009 ISSUE SHALL wait for core_ready=1 and then pulse core_init (first block of message) or core_next (otherwise) for exactly one cycle, then go to WAIT.
REQ-010 core_block and core_mode SHALL be stable from entry to ISSUE until WAIT exits.
REQ-011 WAIT SHALL exit on core_ready=1, going to:
- EXTRA if an extra block is pending;
- FILL with the buffer cleared and w=0 if more message is expected;
- FILL with msg_done pulsed in that exit cycle if the final block is done. busy then clears; the counter and first-block flag reset.
REQ-012 EXTRA SHALL load the extra block in one cycle and go to ISSUE.
REQ-013 A zero-length message is unsupported; s_last with no prior data is a one-word message of b bytes.
REQ-014 s_valid held during ISSUE/WAIT/EXTRA SHALL neither lose nor duplicate data.

Reset
REQ-015 On reset_n low, asynchronously:
- state SHALL be FILL, and w, the counter, the buffer, the pending and first-block flags SHALL be 0;
- core_init, core_next, core_mode, busy and msg_done SHALL be 0, and core_block SHALL be all zero;
- s_ready SHALL be 1 after release.
REQ-016 Reset mid-message SHALL abandon the message with no pulse on core_init, core_next or msg_done.

Structure
REQ-017 The shared package sha256_pkg SHALL hold the FSM state typedef, the pad byte 0x80 and the single-block limit 55.
REQ-018 One combinational sub-module, sha256_pad_mask, SHALL map (w, b) to the 512-bit keep/0x80 insertion masks.

Verification
REQ-019 "abc": s_data=0x61626300, s_bytes=3, s_last -> single core_init; block word0=0x61626380, word15=0x00000018; digest ba7816bf...15ad; one msg_done.
REQ-020 55-byte message -> one block; byte 55 = 0x80; word15=0x000001B8; no core_next.
REQ-021 56-byte message -> core_init then core_next; second block words 0-13 zero, word15=0x000001C0.
REQ-022 64-byte message -> two blocks; second block word0=0x80000000, word15=0x00000200.
REQ-023 Backpressure: 20-word message with s_valid held high throughout -> s_ready=0 during ISSUE/WAIT, and all 20 words hashed in order.
REQ-024 Reset_n pulsed low during WAIT -> all outputs take reset values at once; the next "abc" message yields the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 stream padder.
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EXTRA = 2'd3
    } pad_state_t;

    localparam logic [7:0] PAD_BYTE     = 8'h80;
    localparam int         SINGLE_LIMIT = 55;

endpackage

// File: rtl/sha256_pad_mask.sv
// Maps final-word position (w, b) to the byte keep mask and the 0x80 marker.
module sha256_pad_mask
    import sha256_pkg::*;
(
    input  logic [3:0]   w,
    input  logic [2:0]   b,
    output logic [6:0]   n,
    output logic [511:0] keep,
    output logic [511:0] pad
);

    assign n = {1'b0, w, 2'b00} + {4'b0000, b};

    always_comb begin
        keep = '0;
        pad  = '0;
        for (int k = 0; k < 64; k++) begin
            if (k < int'(n)) begin
                keep[511-8*k -: 8] = 8'hFF;
            end else if (k == int'(n)) begin
                pad[511-8*k -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha256_stream_padder.sv
// Packs a 32-bit message stream into padded 512-bit SHA-256 blocks.
module sha256_stream_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [1:0]   s_bytes,
    input  logic         mode,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    output logic         busy,
    output logic         msg_done
);

    pad_state_t       state;
    logic [3:0]       w;
    logic [LEN_W-1:0] cnt;
    logic [511:0]     blk;
    logic             pend;
    logic             pend_80;
    logic             last_blk;
    logic             first_done;

    logic [2:0]       b;
    logic [6:0]       n;
    logic [511:0]     keep;
    logic [511:0]     pad;
    logic [511:0]     wr_blk;
    logic [511:0]     fin_blk;
    logic [LEN_W-1:0] cnt_add;
    logic [LEN_W-1:0] cnt_nxt;
    logic             accept;

    assign s_ready    = (state == FILL);
    assign accept     = s_valid && s_ready;
    assign core_block = blk;

    sha256_pad_mask u_mask (
        .w    (w),
        .b    (b),
        .n    (n),
        .keep (keep),
        .pad  (pad)
    );

    always_comb begin
        b       = (s_bytes == 2'd0) ? 3'd4 : {1'b0, s_bytes};
        cnt_add = s_last ? LEN_W'({b, 3'b000}) : LEN_W'(32);
        cnt_nxt = cnt + cnt_add;
        wr_blk  = blk;
        wr_blk[32*(15-int'(w)) +: 32] = s_data;
        fin_blk = (wr_blk & keep) | pad;
        if (int'(n) <= SINGLE_LIMIT) begin
            fin_blk[63:0] = 64'(cnt_nxt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FILL;
            w          <= '0;
            cnt        <= '0;
            blk        <= '0;
            pend       <= 1'b0;
            pend_80    <= 1'b0;
            last_blk   <= 1'b0;
            first_done <= 1'b0;
            core_init  <= 1'b0;
            core_next  <= 1'b0;
            core_mode  <= 1'b0;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;
            msg_done  <= 1'b0;
            unique case (state)
                FILL: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (!busy) begin
                            core_mode <= mode;
                        end
                        cnt <= cnt_nxt;
                        if (s_last) begin
                            blk      <= fin_blk;
                            pend     <= int'(n) > SINGLE_LIMIT;
                            pend_80  <= (n == 7'd64);
                            last_blk <= int'(n) <= SINGLE_LIMIT;
                            state    <= ISSUE;
                        end else begin
                            blk <= wr_blk;
                            w   <= w + 4'd1;
                            if (w == 4'd15) begin
                                state <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (core_ready) begin
                        core_init  <= !first_done;
                        core_next  <= first_done;
                        first_done <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // core_ready still shows idle while the core sees the pulse
                    if (core_ready && !core_init && !core_next) begin
                        if (pend) begin
                            state <= EXTRA;
                        end else begin
                            blk   <= '0;
                            w     <= '0;
                            state <= FILL;
                            if (last_blk) begin
                                msg_done   <= 1'b1;
                                busy       <= 1'b0;
                                cnt        <= '0;
                                first_done <= 1'b0;
                                last_blk   <= 1'b0;
                            end
                        end
                    end
                end
                EXTRA: begin
                    blk      <= {(pend_80 ? {PAD_BYTE, 24'h0} : 32'h0),
                                 416'h0, 64'(cnt)};
                    pend     <= 1'b0;
                    last_blk <= 1'b1;
                    state    <= ISSUE;
                end
            endcase
        end
    end

endmodule
